csf_fiber_walker: RTL and testbench

- Upstream stage of the tensaurus coordinate decoder.
- Walks a compressed-sparse-row fiber structure held in two synchronous-read memories: a row-pointer array and a coordinate array.
- Emits the token stream the decoder consumes:
  - header tokens: nnz_addr = 0, i_or_j = row i.
  - entry tokens: nnz_addr = 1-based nonzero position, i_or_j = j, k = k.
- Includes start/done control, per-token valid/ready handshake and pointer-overflow detection.

---
 rtl/csf_fiber_walker_if.sv | 34 +++
 rtl/csf_fiber_walker.sv | 201 ++++++++++++++++++++
 tb/tb_csf_fiber_walker.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csf_fiber_walker_if.sv
// Memory-read and token-stream bundle between the CSF fiber walker and its
// pointer/coordinate memories plus the downstream coordinate decoder.
interface csf_fiber_walker_if #(
  parameter int MEMORY_ADDRESS_SIZE = 10,
  parameter int INDEX_SIZE          = 8
);
  logic                           ptr_rd_en;
  logic [INDEX_SIZE:0]            ptr_rd_addr;
  logic [MEMORY_ADDRESS_SIZE:0]   ptr_rd_data;
  logic                           crd_rd_en;
  logic [MEMORY_ADDRESS_SIZE-1:0] crd_rd_addr;
  logic [INDEX_SIZE-1:0]          crd_j_data;
  logic [INDEX_SIZE-1:0]          crd_k_data;
  logic [MEMORY_ADDRESS_SIZE-1:0] nnz_addr;
  logic [INDEX_SIZE-1:0]          i_or_j;
  logic [INDEX_SIZE-1:0]          k;
  logic                           out_valid;
  logic                           out_ready;

  // Token handshake: a token transfers on a rising edge where out_valid and
  // out_ready are both high; once out_valid rises, the token stays unchanged
  // until that transfer, and out_valid never drops without one.
  modport master (
    output ptr_rd_en, ptr_rd_addr, input ptr_rd_data,
    output crd_rd_en, crd_rd_addr, input crd_j_data, crd_k_data,
    output nnz_addr, i_or_j, k, out_valid, input out_ready
  );

  modport slave (
    input ptr_rd_en, ptr_rd_addr, output ptr_rd_data,
    input crd_rd_en, crd_rd_addr, output crd_j_data, crd_k_data,
    input nnz_addr, i_or_j, k, out_valid, output out_ready
  );
endinterface

// File: rtl/csf_fiber_walker.sv
// Walks a CSR fiber (row pointers + coordinates) and emits header/entry tokens
// for the tensaurus coordinate decoder.
module csf_fiber_walker #(
  parameter int MEMORY_ADDRESS_SIZE = 10,
  parameter int INDEX_SIZE          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INDEX_SIZE-1:0] num_rows,
  output logic                  busy,
  output logic                  done,
  output logic                  err_ovf,
  output logic [2:0]            o_dbg_state,
  csf_fiber_walker_if.master    bus
);
  localparam int M = MEMORY_ADDRESS_SIZE;
  localparam int N = INDEX_SIZE;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PTR_LO  = 3'd1,
    PTR_HI  = 3'd2,
    PTR_CAP = 3'd3,
    HDR     = 3'd4,
    ENT_RD  = 3'd5,
    ENT_OUT = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_num_rows;
  logic [N:0]     r_i;
  logic [M:0]     r_lo;
  logic [M-1:0]   r_hi;
  logic [M-1:0]   r_p;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic           r_ptr_rd_en;
  logic [N:0]     r_ptr_rd_addr;
  logic           r_crd_rd_en;
  logic [M-1:0]   r_crd_rd_addr;
  logic [M-1:0]   r_nnz;
  logic [N-1:0]   r_ij;
  logic [N-1:0]   r_k;
  logic           r_valid;

  logic [N:0]     w_i_next;
  logic [M-1:0]   w_p_next;
  logic           w_last_row;
  logic           w_accept;

  assign w_i_next   = r_i + 1'b1;
  assign w_p_next   = r_p + 1'b1;
  assign w_last_row = (w_i_next == {1'b0, r_num_rows});
  assign w_accept   = r_valid & bus.out_ready;

  // The coordinate read for an entry is issued one cycle early (alongside the
  // header or the previous entry) so its data is already on the bus in ENT_RD.
  // A stalled token never re-reads; the memory output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_num_rows    <= '0;
      r_i           <= '0;
      r_lo          <= '0;
      r_hi          <= '0;
      r_p           <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_ptr_rd_en   <= 1'b0;
      r_ptr_rd_addr <= '0;
      r_crd_rd_en   <= 1'b0;
      r_crd_rd_addr <= '0;
      r_nnz         <= '0;
      r_ij          <= '0;
      r_k           <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_ptr_rd_en <= 1'b0;
      r_crd_rd_en <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_num_rows <= num_rows;
            r_i        <= '0;
            r_ij       <= '0;
            r_err      <= 1'b0;
            if (num_rows == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state       <= PTR_LO;
              r_busy        <= 1'b1;
              r_done        <= 1'b0;
              r_ptr_rd_en   <= 1'b1;
              r_ptr_rd_addr <= '0;
            end
          end
        end
        PTR_LO: begin
          r_ptr_rd_en   <= 1'b1;
          r_ptr_rd_addr <= w_i_next;
          r_state       <= PTR_HI;
        end
        PTR_HI: begin
          r_lo    <= bus.ptr_rd_data;
          r_state <= PTR_CAP;
        end
        PTR_CAP: begin
          if (bus.ptr_rd_data[M]) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (bus.ptr_rd_data == r_lo) begin
            r_i  <= w_i_next;
            r_ij <= w_i_next[N-1:0];
            if (w_last_row) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state       <= PTR_LO;
              r_ptr_rd_en   <= 1'b1;
              r_ptr_rd_addr <= w_i_next;
            end
          end else begin
            r_hi          <= bus.ptr_rd_data[M-1:0];
            r_p           <= r_lo[M-1:0];
            r_crd_rd_en   <= 1'b1;
            r_crd_rd_addr <= r_lo[M-1:0];
            r_nnz         <= '0;
            r_ij          <= r_i[N-1:0];
            r_k           <= '0;
            r_valid       <= 1'b1;
            r_state       <= HDR;
          end
        end
        HDR: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_state <= ENT_RD;
          end
        end
        ENT_RD: begin
          r_nnz   <= w_p_next;
          r_ij    <= bus.crd_j_data;
          r_k     <= bus.crd_k_data;
          r_valid <= 1'b1;
          if (w_p_next != r_hi) begin
            r_crd_rd_en   <= 1'b1;
            r_crd_rd_addr <= w_p_next;
          end
          r_state <= ENT_OUT;
        end
        ENT_OUT: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_nnz   <= '0;
            r_k     <= '0;
            r_ij    <= r_i[N-1:0];
            r_p     <= w_p_next;
            if (w_p_next != r_hi) begin
              r_state <= ENT_RD;
            end else begin
              r_i  <= w_i_next;
              r_ij <= w_i_next[N-1:0];
              if (w_last_row) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state       <= PTR_LO;
                r_ptr_rd_en   <= 1'b1;
                r_ptr_rd_addr <= w_i_next;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign err_ovf         = r_err;
  assign o_dbg_state     = r_state;
  assign bus.ptr_rd_en   = r_ptr_rd_en;
  assign bus.ptr_rd_addr = r_ptr_rd_addr;
  assign bus.crd_rd_en   = r_crd_rd_en;
  assign bus.crd_rd_addr = r_crd_rd_addr;
  assign bus.nnz_addr    = r_nnz;
  assign bus.i_or_j      = r_ij;
  assign bus.k           = r_k;
  assign bus.out_valid   = r_valid;
endmodule

// File: tb/tb_csf_fiber_walker.sv
// Directed bench for csf_fiber_walker: synchronous-read memory models, token
// monitor, and one task per scenario with hand-computed token streams.
module tb_csf_fiber_walker;
  localparam int M = 10;
  localparam int N = 8;
  localparam int W = M + 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] num_rows;
  logic         busy;
  logic         done;
  logic         err_ovf;
  logic [2:0]   dbg_state;

  csf_fiber_walker_if #(.MEMORY_ADDRESS_SIZE(M), .INDEX_SIZE(N)) bus ();

  csf_fiber_walker #(.MEMORY_ADDRESS_SIZE(M), .INDEX_SIZE(N)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .err_ovf(err_ovf), .o_dbg_state(dbg_state),
    .bus(bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory models ----------------
  logic [M:0]   ptr_mem [16];
  logic [N-1:0] j_mem   [16];
  logic [N-1:0] k_mem   [16];

  always @(posedge clk) begin
    if (bus.ptr_rd_en) bus.ptr_rd_data <= ptr_mem[bus.ptr_rd_addr[3:0]];
    if (bus.crd_rd_en) begin
      bus.crd_j_data <= j_mem[bus.crd_rd_addr[3:0]];
      bus.crd_k_data <= k_mem[bus.crd_rd_addr[3:0]];
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int ptr_reads = 0;
  int crd_reads = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back({bus.nnz_addr, bus.i_or_j, bus.k});
      if (bus.ptr_rd_en) ptr_reads++;
      if (bus.crd_rd_en) crd_reads++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 16; a++) begin
      ptr_mem[a] = '0;
      j_mem[a]   = '0;
      k_mem[a]   = '0;
    end
  endtask

  task automatic load_scn1();
    clear_mem();
    ptr_mem[0] = 11'd0; ptr_mem[1] = 11'd2; ptr_mem[2] = 11'd3;
    j_mem[0] = 8'd5; j_mem[1] = 8'd7; j_mem[2] = 8'd1;
    k_mem[0] = 8'd9; k_mem[1] = 8'd4; k_mem[2] = 8'd2;
  endtask

  task automatic exp_scn1();
    exp_q.delete();
    exp_q.push_back({10'd0, 8'd0, 8'd0});
    exp_q.push_back({10'd1, 8'd5, 8'd9});
    exp_q.push_back({10'd2, 8'd7, 8'd4});
    exp_q.push_back({10'd0, 8'd1, 8'd0});
    exp_q.push_back({10'd3, 8'd1, 8'd2});
  endtask

  task automatic pulse_start(input logic [N-1:0] n);
    start    = 1'b1;
    num_rows = n;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_rows = '0; bus.out_ready = 1'b1;
    clear_mem();
    tick(); tick(); tick();
    n_tests++;
    if ({busy, done, err_ovf, bus.out_valid, bus.ptr_rd_en, bus.crd_rd_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, done, err_ovf, bus.out_valid, bus.ptr_rd_en, bus.crd_rd_en});
    end
    n_tests++;
    if ({bus.nnz_addr, bus.i_or_j, bus.k, bus.ptr_rd_addr, bus.crd_rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got nnz=%0d ij=%0d k=%0d pa=%0d ca=%0d expected all 0",
               bus.nnz_addr, bus.i_or_j, bus.k, bus.ptr_rd_addr, bus.crd_rd_addr);
    end
    n_tests++;
    if (dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_walk();
    int cyc, gb, pb, cb;
    load_scn1(); exp_scn1();
    gb = got_q.size(); pb = ptr_reads; cb = crd_reads;
    pulse_start(8'd2);
    wait_done(100, cyc);
    n_tests++;
    if (cyc !== 14) begin n_fail++; $display("FAIL basic_cycles: got %0d expected 14", cyc); end
    n_tests++;
    if ({done, busy, err_ovf} !== 3'b100) begin
      n_fail++; $display("FAIL basic_status: got done/busy/err=%b expected 100", {done, busy, err_ovf});
    end
    n_tests++;
    if ({bus.out_valid, bus.nnz_addr, bus.i_or_j, bus.k} !== {1'b0, 10'd0, 8'd2, 8'd0}) begin
      n_fail++; $display("FAIL basic_filler: got v=%b nnz=%0d ij=%0d k=%0d expected 0/0/2/0",
                         bus.out_valid, bus.nnz_addr, bus.i_or_j, bus.k);
    end
    n_tests++;
    if (ptr_reads - pb !== 4 || crd_reads - cb !== 3) begin
      n_fail++; $display("FAIL basic_reads: got ptr=%0d crd=%0d expected 4/3", ptr_reads - pb, crd_reads - cb);
    end
    n_tests++;
    if (got_q.size() - gb !== exp_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d tokens expected %0d", got_q.size() - gb, exp_q.size());
    end
    foreach (exp_q[x]) begin
      n_tests++;
      if (gb + x >= got_q.size() || got_q[gb + x] !== exp_q[x]) begin
        n_fail++; $display("FAIL basic_token%0d: got %h expected %h", x,
                           (gb + x < got_q.size()) ? got_q[gb + x] : 'x, exp_q[x]);
      end
    end
  endtask

  task automatic test_empty_rows();
    int cyc, gb, pb, cb;
    clear_mem();
    ptr_mem[0] = 11'd0; ptr_mem[1] = 11'd0; ptr_mem[2] = 11'd1; ptr_mem[3] = 11'd1;
    j_mem[0] = 8'd3; k_mem[0] = 8'd6;
    exp_q.delete();
    exp_q.push_back({10'd0, 8'd1, 8'd0});
    exp_q.push_back({10'd1, 8'd3, 8'd6});
    gb = got_q.size(); pb = ptr_reads; cb = crd_reads;
    pulse_start(8'd3);
    wait_done(100, cyc);
    n_tests++;
    if (cyc !== 12 || done !== 1'b1) begin
      n_fail++; $display("FAIL empty_cycles: got %0d done=%b expected 12 done=1", cyc, done);
    end
    n_tests++;
    if (ptr_reads - pb !== 6 || crd_reads - cb !== 1) begin
      n_fail++; $display("FAIL empty_reads: got ptr=%0d crd=%0d expected 6/1", ptr_reads - pb, crd_reads - cb);
    end
    n_tests++;
    if (got_q.size() - gb !== exp_q.size()) begin
      n_fail++; $display("FAIL empty_count: got %0d tokens expected %0d", got_q.size() - gb, exp_q.size());
    end
    foreach (exp_q[x]) begin
      n_tests++;
      if (gb + x >= got_q.size() || got_q[gb + x] !== exp_q[x]) begin
        n_fail++; $display("FAIL empty_token%0d: got %h expected %h", x,
                           (gb + x < got_q.size()) ? got_q[gb + x] : 'x, exp_q[x]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc, gb, cb, n;
    load_scn1(); exp_scn1();
    gb = got_q.size(); cb = crd_reads;
    pulse_start(8'd2);
    n = 0;
    while (!(bus.out_valid && bus.nnz_addr == 10'd1) && n < 50) begin
      tick();
      n++;
    end
    n_tests++;
    if (!(bus.out_valid && bus.nnz_addr == 10'd1)) begin
      n_fail++; $display("FAIL bp_find: got v=%b nnz=%0d expected v=1 nnz=1", bus.out_valid, bus.nnz_addr);
    end
    bus.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_tests++;
      if ({bus.out_valid, bus.crd_rd_en, bus.nnz_addr, bus.i_or_j, bus.k} !==
          {1'b1, 1'b0, 10'd1, 8'd5, 8'd9}) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b rd=%b nnz=%0d ij=%0d k=%0d expected 1/0/1/5/9", s,
                           bus.out_valid, bus.crd_rd_en, bus.nnz_addr, bus.i_or_j, bus.k);
      end
    end
    bus.out_ready = 1'b1;
    wait_done(100, cyc);
    n_tests++;
    if (done !== 1'b1 || crd_reads - cb !== 3) begin
      n_fail++; $display("FAIL bp_done: got done=%b crd=%0d expected 1/3", done, crd_reads - cb);
    end
    n_tests++;
    if (got_q.size() - gb !== exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d tokens expected %0d", got_q.size() - gb, exp_q.size());
    end
    foreach (exp_q[x]) begin
      n_tests++;
      if (gb + x >= got_q.size() || got_q[gb + x] !== exp_q[x]) begin
        n_fail++; $display("FAIL bp_token%0d: got %h expected %h", x,
                           (gb + x < got_q.size()) ? got_q[gb + x] : 'x, exp_q[x]);
      end
    end
  endtask

  task automatic test_zero_rows_and_busy();
    int cyc, gb, pb, cb;
    gb = got_q.size(); pb = ptr_reads; cb = crd_reads;
    pulse_start(8'd0);
    wait_done(10, cyc);
    n_tests++;
    if (cyc !== 0 || {done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL zero_done: got cyc=%0d done/busy=%b expected 0/10", cyc, {done, busy});
    end
    tick(); tick();
    n_tests++;
    if (ptr_reads - pb !== 0 || crd_reads - cb !== 0 || got_q.size() - gb !== 0) begin
      n_fail++; $display("FAIL zero_quiet: got ptr=%0d crd=%0d tok=%0d expected 0/0/0",
                         ptr_reads - pb, crd_reads - cb, got_q.size() - gb);
    end
    load_scn1(); exp_scn1();
    gb = got_q.size();
    pulse_start(8'd2);
    tick(); tick();
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_high: got %b expected 1", busy); end
    pulse_start(8'd0);
    wait_done(100, cyc);
    n_tests++;
    if (cyc !== 11 || done !== 1'b1) begin
      n_fail++; $display("FAIL busy_ignore_cycles: got %0d done=%b expected 11 done=1", cyc, done);
    end
    n_tests++;
    if (got_q.size() - gb !== exp_q.size()) begin
      n_fail++; $display("FAIL busy_count: got %0d tokens expected %0d", got_q.size() - gb, exp_q.size());
    end
    foreach (exp_q[x]) begin
      n_tests++;
      if (gb + x >= got_q.size() || got_q[gb + x] !== exp_q[x]) begin
        n_fail++; $display("FAIL busy_token%0d: got %h expected %h", x,
                           (gb + x < got_q.size()) ? got_q[gb + x] : 'x, exp_q[x]);
      end
    end
  endtask

  task automatic test_overflow();
    int cyc, gb;
    clear_mem();
    ptr_mem[0] = 11'd0; ptr_mem[1] = 11'd1024;
    gb = got_q.size();
    pulse_start(8'd1);
    wait_done(50, cyc);
    n_tests++;
    if (cyc !== 3 || {done, busy, err_ovf} !== 3'b101) begin
      n_fail++; $display("FAIL ovf_flag: got cyc=%0d done/busy/err=%b expected 3/101", cyc, {done, busy, err_ovf});
    end
    n_tests++;
    if (got_q.size() - gb !== 0) begin
      n_fail++; $display("FAIL ovf_tokens: got %0d expected 0", got_q.size() - gb);
    end
    pulse_start(8'd0);
    n_tests++;
    if ({done, err_ovf} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_clear: got done/err=%b expected 10", {done, err_ovf});
    end
  endtask

  task automatic test_reset_mid_walk();
    int cyc, gb, pb, cb, n;
    load_scn1(); exp_scn1();
    pulse_start(8'd2);
    n = 0;
    while (dbg_state !== 3'd6 && n < 50) begin
      tick();
      n++;
    end
    n_tests++;
    if (dbg_state !== 3'd6) begin n_fail++; $display("FAIL rst_find: got state %0d expected 6", dbg_state); end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({busy, done, err_ovf, bus.out_valid, bus.ptr_rd_en, bus.crd_rd_en, dbg_state} !== 9'b0 ||
        {bus.nnz_addr, bus.i_or_j, bus.k, bus.ptr_rd_addr, bus.crd_rd_addr} !== '0) begin
      n_fail++; $display("FAIL rst_values: got flags=%b st=%0d nnz=%0d ij=%0d k=%0d pa=%0d ca=%0d expected all 0",
                         {busy, done, err_ovf, bus.out_valid, bus.ptr_rd_en, bus.crd_rd_en}, dbg_state,
                         bus.nnz_addr, bus.i_or_j, bus.k, bus.ptr_rd_addr, bus.crd_rd_addr);
    end
    rst = 1'b0;
    gb = got_q.size(); pb = ptr_reads; cb = crd_reads;
    tick(); tick(); tick(); tick();
    n_tests++;
    if (ptr_reads - pb !== 0 || crd_reads - cb !== 0 || got_q.size() - gb !== 0) begin
      n_fail++; $display("FAIL rst_quiet: got ptr=%0d crd=%0d tok=%0d expected 0/0/0",
                         ptr_reads - pb, crd_reads - cb, got_q.size() - gb);
    end
    gb = got_q.size();
    pulse_start(8'd2);
    wait_done(100, cyc);
    n_tests++;
    if (cyc !== 14 || done !== 1'b1) begin
      n_fail++; $display("FAIL rst_rerun_cycles: got %0d done=%b expected 14 done=1", cyc, done);
    end
    n_tests++;
    if (got_q.size() - gb !== exp_q.size()) begin
      n_fail++; $display("FAIL rst_count: got %0d tokens expected %0d", got_q.size() - gb, exp_q.size());
    end
    foreach (exp_q[x]) begin
      n_tests++;
      if (gb + x >= got_q.size() || got_q[gb + x] !== exp_q[x]) begin
        n_fail++; $display("FAIL rst_token%0d: got %h expected %h", x,
                           (gb + x < got_q.size()) ? got_q[gb + x] : 'x, exp_q[x]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_walk();
    test_empty_rows();
    test_backpressure();
    test_zero_rows_and_busy();
    test_overflow();
    test_reset_mid_walk();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
